// File: rtl/fifo.sv
// Single-clock FIFO with registered read data and full/empty flags.
// Writes into a full FIFO and reads from an empty FIFO are dropped.
module fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rden,
    input  logic                  wren,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_full;
    logic                  r_empty;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [CNT_W-1:0]      w_count_nxt;

    // Accept decisions use the pre-edge flags, so simultaneous requests are judged independently.
    assign w_wr_acc = wren && !r_full;
    assign w_rd_acc = rden && !r_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage array; contents are don't-care after reset so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
        end
    end

    // Flags are registered alongside the count so they track it exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (w_rd_acc) begin
            r_rdata <= r_mem[r_rptr];
        end
    end

    assign o_data = r_rdata;
    assign full   = r_full;
    assign empty  = r_empty;

endmodule

// File: tb/tb_fifo.sv
// Scoreboard bench for fifo: directed vectors push hand-computed expectations,
// a negedge monitor pops and compares o_data/full/empty.
module tb_fifo;

    logic       clk;
    logic       rst_n;
    logic       rden;
    logic       wren;
    logic [7:0] i_data;
    logic [7:0] o_data;
    logic       full;
    logic       empty;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] o;
        logic       f;
        logic       e;
        string      nm;
    } exp_t;

    exp_t sb_q[$];

    logic [7:0] fill_data [8];

    fifo #(.DATA_WIDTH(8), .DEPTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rden   (rden),
        .wren   (wren),
        .i_data (i_data),
        .o_data (o_data),
        .full   (full),
        .empty  (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // One clock of stimulus; expectation is queued after the sampling edge.
    task automatic step(input logic w, input logic r, input logic [7:0] d,
                        input logic [7:0] eo, input logic ef, input logic ee,
                        input string nm);
        exp_t x;
        @(negedge clk);
        wren   = w;
        rden   = r;
        i_data = d;
        @(posedge clk);
        #1;
        wren = 1'b0;
        rden = 1'b0;
        x.o  = eo;
        x.f  = ef;
        x.e  = ee;
        x.nm = nm;
        sb_q.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                chk({x.nm, "_odata"}, o_data, x.o);
                chk({x.nm, "_full"},  8'(full),  8'(x.f));
                chk({x.nm, "_empty"}, 8'(empty), 8'(x.e));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        fill_data[0] = 8'h3C; fill_data[1] = 8'hA5; fill_data[2] = 8'h17; fill_data[3] = 8'hE2;
        fill_data[4] = 8'h5B; fill_data[5] = 8'h90; fill_data[6] = 8'h6D; fill_data[7] = 8'hC4;

        rst_n  = 1'b0;
        wren   = 1'b0;
        rden   = 1'b0;
        i_data = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_odata", o_data, 8'h00);
        chk("reset_full",  8'(full),  8'h00);
        chk("reset_empty", 8'(empty), 8'h01);

        // Fill to full, then one dropped overflow write.
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b0, fill_data[i], 8'h00, (i == 7), 1'b0, $sformatf("fill%0d", i));
        step(1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, "overflow");

        // Drain in order; 0xFF must never appear.
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b1, 8'h00, fill_data[i], 1'b0, (i == 7), $sformatf("drain%0d", i));

        // Underflow holds last data.
        step(1'b0, 1'b1, 8'h00, 8'hC4, 1'b0, 1'b1, "underflow0");
        step(1'b0, 1'b1, 8'h00, 8'hC4, 1'b0, 1'b1, "underflow1");

        // Simultaneous read/write across pointer wrap.
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 8'(i + 1), 8'hC4, 1'b0, 1'b0, $sformatf("pre%0d", i));
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 8'hA0 + 8'(i), 8'(i + 1), 1'b0, 1'b0, $sformatf("rw%0d", i));
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 8'hC0 + 8'(i), (i == 0) ? 8'h04 : 8'hA0 + 8'(i - 1),
                 1'b0, 1'b0, $sformatf("cw%0d", i));
            step(1'b0, 1'b1, 8'h00, 8'hA0 + 8'(i), 1'b0, 1'b0, $sformatf("cr%0d", i));
        end

        // Top up to full (A3,C0,C1,C2 already stored), then reset between edges.
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 8'hD0 + 8'(i), 8'hA2, (i == 3), 1'b0, $sformatf("dw%0d", i));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_odata", o_data, 8'h00);
        chk("midrst_full",  8'(full),  8'h00);
        chk("midrst_empty", 8'(empty), 8'h01);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst_odata", o_data, 8'h00);
        chk("postrst_full",  8'(full),  8'h00);
        chk("postrst_empty", 8'(empty), 8'h01);

        // Simultaneous on empty: only the write proceeds, o_data holds.
        step(1'b1, 1'b1, 8'h77, 8'h00, 1'b0, 1'b0, "rw_empty");
        step(1'b0, 1'b1, 8'h00, 8'h77, 1'b0, 1'b1, "rd_77");

        // Simultaneous on full: only the read proceeds, 0xEE is dropped.
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b0, 8'h10 + 8'(i), 8'h77, (i == 7), 1'b0, $sformatf("f2_%0d", i));
        step(1'b1, 1'b1, 8'hEE, 8'h10, 1'b0, 1'b0, "rw_full");
        for (int i = 1; i < 8; i++)
            step(1'b0, 1'b1, 8'h00, 8'h10 + 8'(i), 1'b0, (i == 7), $sformatf("d2_%0d", i));
        step(1'b0, 1'b1, 8'h00, 8'h17, 1'b0, 1'b1, "final_under");

        for (int n = 0; n < 10 && sb_q.size() > 0; n++)
            @(negedge clk);
        #1;
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
